relogio_posse: RTL and testbench
================================

# relogio_posse

- Parametrised shot clock (possession timer) for the basketball scoreboard.
- Counts down from a full or short preset in seconds and tenths, freezes while paused, and flags expiry with a timed buzzer pulse.
- Sits between the switch/button conditioning logic and the display/buzzer drivers; successor of the fixed 24/14-second countdown.
- Adds tenths resolution, the "short reset only when below short value" rule, pause without losing the sub-second phase, and a bounded buzzer.

## Interface
- TICKS_PER_TENTH, default 5_000_000: clock cycles per 0.1 s (50 MHz board clock).
- WIDTH, default 5: seconds field width; must satisfy FULL_VAL < 2**WIDTH.
- FULL_VAL, default 24: full possession preset, seconds.
- SHORT_VAL, default 14: short preset, seconds; must satisfy 0 < SHORT_VAL <= FULL_VAL.
- BUZZ_CYCLES, default 50_000_000: buzzer high time in clock cycles; must be >= 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_full  in  1  synchronous request; load FULL_VAL.0 when sampled high.
- load_short  in  1  synchronous request; conditional load of SHORT_VAL.0.
- pause  in  1  level input; 1 = frozen, 0 = running.
- segundos  out  WIDTH  current seconds.
- decimos  out  4  current tenths, 0..9.
- running  out  1  1 while in RUN state.
- expired  out  1  1 while in EXPIRED state.
- buzzer  out  1  expiry horn.

## Operation
- States:
  - STOPPED: value held.
  - RUN: counting down.
  - EXPIRED: value at 0.0.
- Transitions:
  - STOPPED→RUN when pause=0 and value≠0.0.
  - RUN→STOPPED when pause=1.
  - RUN→EXPIRED on the decrement that reaches 0.0.
  - Any load request: EXPIRED→STOPPED, or EXPIRED→RUN if pause=0 on that edge.
- Decrement on each prescaler tick in RUN:
  - decimos>0: decimos−1.
  - decimos=0: decimos=9, segundos−1.
  - No wrap below 0.0.
- load_full:
  - Value := FULL_VAL.0 and prescaler cleared, in any state.
- load_short:
  - Value := SHORT_VAL.0 and prescaler cleared only when current segundos < SHORT_VAL or state=EXPIRED.
  - Otherwise ignored; value and prescaler untouched.
- Both loads high on the same edge: load_full wins.
- Pause holds the prescaler count, so resuming continues the partial tenth.
- Buzzer:
  - Rises on entry to EXPIRED and stays high exactly BUZZ_CYCLES cycles, then falls.
  - Any accepted load drops the buzzer on that edge and aborts the pulse.
- expired stays 1 until an accepted load; pause has no effect in EXPIRED.
- Loads held high across several cycles act as repeated loads: the value stays at the preset and the prescaler stays at 0.

## Timing
- Reset values:
  - segundos=FULL_VAL, decimos=0.
  - State STOPPED, so running=0; expired=0; buzzer=0.
  - Prescaler=0.
- All outputs are registered; inputs take effect on the first rising edge at which they are sampled, and outputs show the result after that edge.
- From a load with pause=0, the first decrement lands TICKS_PER_TENTH cycles after the load edge.
- Full run from FULL_VAL.0 to 0.0 takes FULL_VAL·10·TICKS_PER_TENTH cycles with no pause.
- expired and buzzer rise on the same edge where the value becomes 0.0.
- reset_n asserted mid-run or mid-buzz forces reset values immediately (asynchronously); counting restarts only after deassertion, with a fresh prescaler phase.
- Inputs are already synchronised and debounced upstream; this block performs no synchronisation.

## Structure
- Package relogio_pkg:
  - State enum: STOPPED, RUN, EXPIRED.
  - Constant TENTHS_MAX = 9.
  - Width function for the prescaler and buzzer counters (clog2-based).
- Sub-module divisor_decimo, parameterised by TICKS_PER_TENTH:
  - Ports: clock, reset_n, enable, clear, tick.
  - tick is a one-cycle pulse each time the counter reaches TICKS_PER_TENTH−1 while enable=1.
  - clear has priority over enable.
- Top level holds:
  - The FSM.
  - The seconds/tenths down-counter.
  - The buzzer duration counter.

## Test plan
All scenarios use TICKS_PER_TENTH=4, FULL_VAL=24, SHORT_VAL=14, BUZZ_CYCLES=8.

- Reset, then release with pause=1:
  - segundos=24, decimos=0, running=0, expired=0, buzzer=0.
  - Outputs remain unchanged for 100 cycles.
- Countdown and expiry:
  - Drive load_full then pause=0: 24.0→23.9 after 4 cycles.
  - 0.0 reached 960 cycles after the load edge.
  - expired=1, and buzzer high for exactly 8 cycles.
- Short-reset rule:
  - At 18.3, pulse load_short: value stays 18.3.
  - At 9.7, pulse load_short: value becomes 14.0 and the prescaler restarts (14.0→13.9 4 cycles later).
- Pause phase:
  - Set pause=1 two cycles into a tenth, hold 50 cycles, then release.
  - Next decrement occurs 2 cycles after release; the value is unchanged during the pause.
- Simultaneous and mid-buzz loads:
  - load_full and load_short together at 5.0 give 24.0.
  - load_short on the 3rd buzzer cycle: buzzer=0 and expired=0 on that edge; value 14.0; running=1 when pause=0.
- Asynchronous reset at 7.4 while running:
  - Outputs go to reset values without waiting for a clock edge.
  - After release, no decrement occurs while pause=1.

Source files
------------

// File: rtl/relogio_pkg.sv
// Shared types and helpers for the shot clock: FSM state encoding, tenths limit
// and the counter-width helper used by the prescaler and the buzzer timer.
package relogio_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } estado_t;

    localparam logic [3:0] TENTHS_MAX = 4'd9;

    // Bits needed to hold 0..n-1, never less than one bit.
    function automatic int largura(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/divisor_decimo.sv
// Tenth-of-second prescaler: counts enabled cycles and pulses tick on the last
// count of each tenth. The count is held while disabled so a paused tenth resumes.
module divisor_decimo
    import relogio_pkg::*;
#(
    parameter int TICKS_PER_TENTH = 5_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = largura(TICKS_PER_TENTH);
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_TENTH - 1);

    logic [CW-1:0] conta_r;
    logic          fim_s;

    // Tick decode straight off the count so the decrement lands on the edge that wraps it
    always_comb begin
        fim_s = 1'b0;
        if (enable && !clear && (conta_r == LAST)) begin
            fim_s = 1'b1;
        end else begin
            fim_s = 1'b0;
        end
    end

    assign tick = fim_s;

    // Prescaler count: clear beats enable, disabled cycles hold the phase
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            conta_r <= {CW{1'b0}};
        end else if (clear) begin
            conta_r <= {CW{1'b0}};
        end else if (enable) begin
            if (conta_r == LAST) begin
                conta_r <= {CW{1'b0}};
            end else begin
                conta_r <= conta_r + CW'(1);
            end
        end else begin
            conta_r <= conta_r;
        end
    end

endmodule

// File: rtl/relogio_posse.sv
// Shot clock top: STOPPED/RUN/EXPIRED control, seconds.tenths down-counter and
// the bounded expiry buzzer, driven by the divisor_decimo prescaler.
module relogio_posse
    import relogio_pkg::*;
#(
    parameter int TICKS_PER_TENTH = 5_000_000,
    parameter int WIDTH           = 5,
    parameter int FULL_VAL        = 24,
    parameter int SHORT_VAL       = 14,
    parameter int BUZZ_CYCLES     = 50_000_000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_full,
    input  logic             load_short,
    input  logic             pause,
    output logic [WIDTH-1:0] segundos,
    output logic [3:0]       decimos,
    output logic             running,
    output logic             expired,
    output logic             buzzer
);

    localparam int              BW        = largura(BUZZ_CYCLES);
    localparam logic [WIDTH-1:0] FULL_SEG  = WIDTH'(FULL_VAL);
    localparam logic [WIDTH-1:0] SHORT_SEG = WIDTH'(SHORT_VAL);
    localparam logic [BW-1:0]    BUZZ_LAST = BW'(BUZZ_CYCLES - 1);

    estado_t          estado_r;
    estado_t          estado_s;
    logic [WIDTH-1:0] seg_r;
    logic [WIDTH-1:0] seg_s;
    logic [3:0]       dec_r;
    logic [3:0]       dec_s;
    logic [BW-1:0]    buzz_cnt_r;
    logic [BW-1:0]    buzz_cnt_s;
    logic             buzzer_r;
    logic             buzzer_s;
    logic             running_r;
    logic             expired_r;
    logic             short_ok_s;
    logic             load_acc_s;
    logic             nonzero_s;
    logic             enable_s;
    logic             tick_s;

    // Short preset is only honoured below the short value or after expiry
    always_comb begin
        short_ok_s = 1'b0;
        if (load_short && ((seg_r < SHORT_SEG) || (estado_r == EXPIRED))) begin
            short_ok_s = 1'b1;
        end else begin
            short_ok_s = 1'b0;
        end
    end

    assign load_acc_s = load_full | short_ok_s;
    assign nonzero_s  = (seg_r != {WIDTH{1'b0}}) || (dec_r != 4'd0);
    // The prescaler advances on every edge that leaves the FSM counting
    assign enable_s   = !pause && (estado_r != EXPIRED) && nonzero_s;

    divisor_decimo #(
        .TICKS_PER_TENTH(TICKS_PER_TENTH)
    ) u_divisor (
        .clock  (clock),
        .reset_n(reset_n),
        .enable (enable_s),
        .clear  (load_acc_s),
        .tick   (tick_s)
    );

    // Next state and next value: loads first, then pause/run control and decrement
    always_comb begin
        estado_s = estado_r;
        seg_s    = seg_r;
        dec_s    = dec_r;
        if (load_acc_s) begin
            seg_s    = load_full ? FULL_SEG : SHORT_SEG;
            dec_s    = 4'd0;
            estado_s = pause ? STOPPED : RUN;
        end else begin
            case (estado_r)
                STOPPED: begin
                    if (!pause && nonzero_s) begin
                        estado_s = RUN;
                    end else begin
                        estado_s = STOPPED;
                    end
                end
                RUN: begin
                    if (pause) begin
                        estado_s = STOPPED;
                    end else begin
                        estado_s = RUN;
                    end
                end
                EXPIRED: estado_s = EXPIRED;
                default: estado_s = STOPPED;
            endcase
            if (tick_s) begin
                if (dec_r != 4'd0) begin
                    dec_s = dec_r - 4'd1;
                end else begin
                    dec_s = TENTHS_MAX;
                    seg_s = seg_r - WIDTH'(1);
                end
                if ((seg_r == {WIDTH{1'b0}}) && (dec_r == 4'd1)) begin
                    estado_s = EXPIRED;
                end else begin
                    estado_s = estado_s;
                end
            end else begin
                seg_s = seg_r;
                dec_s = dec_r;
            end
        end
    end

    // Buzzer timer: armed on entry to EXPIRED, aborted by any accepted load
    always_comb begin
        buzzer_s   = buzzer_r;
        buzz_cnt_s = buzz_cnt_r;
        if (load_acc_s) begin
            buzzer_s   = 1'b0;
            buzz_cnt_s = {BW{1'b0}};
        end else if ((estado_s == EXPIRED) && (estado_r != EXPIRED)) begin
            buzzer_s   = 1'b1;
            buzz_cnt_s = BUZZ_LAST;
        end else if (buzzer_r) begin
            if (buzz_cnt_r == {BW{1'b0}}) begin
                buzzer_s = 1'b0;
            end else begin
                buzz_cnt_s = buzz_cnt_r - BW'(1);
            end
        end else begin
            buzzer_s   = 1'b0;
            buzz_cnt_s = buzz_cnt_r;
        end
    end

    // State, value, buzzer and registered status flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_r   <= STOPPED;
            seg_r      <= FULL_SEG;
            dec_r      <= 4'd0;
            buzzer_r   <= 1'b0;
            buzz_cnt_r <= {BW{1'b0}};
            running_r  <= 1'b0;
            expired_r  <= 1'b0;
        end else begin
            estado_r   <= estado_s;
            seg_r      <= seg_s;
            dec_r      <= dec_s;
            buzzer_r   <= buzzer_s;
            buzz_cnt_r <= buzz_cnt_s;
            running_r  <= (estado_s == RUN);
            expired_r  <= (estado_s == EXPIRED);
        end
    end

    assign segundos = seg_r;
    assign decimos  = dec_r;
    assign running  = running_r;
    assign expired  = expired_r;
    assign buzzer   = buzzer_r;

endmodule

// File: tb/tb_relogio_posse.sv
// Scoreboard bench for relogio_posse with TICKS_PER_TENTH=4, 24/14 s presets and
// an 8-cycle buzzer; expectations are tagged with the clock edge they follow.
module tb_relogio_posse;

    logic       clock;
    logic       reset_n;
    logic       load_full;
    logic       load_short;
    logic       pause;
    logic [4:0] segundos;
    logic [3:0] decimos;
    logic       running;
    logic       expired;
    logic       buzzer;

    typedef struct {
        int    when;
        string name;
        int    seg;
        int    dec;
        bit    run_x;
        bit    expd_x;
        bit    buz_x;
    } exp_t;

    exp_t sb[$];
    int   pcyc  = 0;
    int   total = 0;
    int   bad   = 0;
    event chk_now;

    relogio_posse #(
        .TICKS_PER_TENTH(4),
        .WIDTH          (5),
        .FULL_VAL       (24),
        .SHORT_VAL      (14),
        .BUZZ_CYCLES    (8)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .load_full (load_full),
        .load_short(load_short),
        .pause     (pause),
        .segundos  (segundos),
        .decimos   (decimos),
        .running   (running),
        .expired   (expired),
        .buzzer    (buzzer)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Edge counter used to tag and retire expectations
    always @(posedge clock) pcyc <= pcyc + 1;

    task automatic push(input int w, input string n, input int s, input int d,
                        input bit r, input bit x, input bit z);
        exp_t e;
        e.when = w; e.name = n; e.seg = s; e.dec = d;
        e.run_x = r; e.expd_x = x; e.buz_x = z;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (pcyc < c) @(negedge clock);
    endtask

    // Monitor: retire every expectation whose edge has passed
    initial begin
        exp_t e;
        forever begin
            @(negedge clock or chk_now);
            while (sb.size() > 0 && sb[0].when <= pcyc) begin
                e = sb.pop_front();
                total++;
                if (segundos !== 5'(e.seg) || decimos !== 4'(e.dec) || running !== e.run_x ||
                    expired !== e.expd_x || buzzer !== e.buz_x) begin
                    bad++;
                    $display("FAIL %s edge=%0d got %0d.%0d run=%0b exp=%0b buz=%0b want %0d.%0d run=%0b exp=%0b buz=%0b",
                             e.name, pcyc, segundos, decimos, running, expired, buzzer,
                             e.seg, e.dec, e.run_x, e.expd_x, e.buz_x);
                end
            end
        end
    end

    initial begin
        int b, l, l2, s, f, e, q0, q;
        reset_n = 1'b0; load_full = 1'b0; load_short = 1'b0; pause = 1'b1;

        // Reset and idle with pause held
        repeat (2) @(negedge clock);
        push(pcyc + 1, "rst_hold", 24, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        b = pcyc;
        for (int k = 1; k <= 100; k++) push(b + k, "idle", 24, 0, 1'b0, 1'b0, 1'b0);
        wait_until(b + 100);

        // Full countdown to expiry and buzzer length
        load_full = 1'b1; pause = 1'b0;
        l = pcyc + 1;
        push(l,       "full_load",  24, 0, 1'b1, 1'b0, 1'b0);
        push(l + 3,   "first_hold", 24, 0, 1'b1, 1'b0, 1'b0);
        push(l + 4,   "first_dec",  23, 9, 1'b1, 1'b0, 1'b0);
        push(l + 8,   "second_dec", 23, 8, 1'b1, 1'b0, 1'b0);
        push(l + 959, "last_tenth",  0, 1, 1'b1, 1'b0, 1'b0);
        push(l + 960, "expiry",      0, 0, 1'b0, 1'b1, 1'b1);
        push(l + 967, "buz_last",    0, 0, 1'b0, 1'b1, 1'b1);
        push(l + 968, "buz_off",     0, 0, 1'b0, 1'b1, 1'b0);
        push(l + 970, "exp_pause",   0, 0, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        load_full = 1'b0;
        wait_until(l + 968);
        pause = 1'b1;
        wait_until(l + 970);
        pause = 1'b0; load_full = 1'b1;

        // Short-reset rule
        l2 = pcyc + 1;
        s  = l2 + 574;
        push(l2,       "reload_exp", 24, 0, 1'b1, 1'b0, 1'b0);
        push(l2 + 229, "short_ign",  18, 3, 1'b1, 1'b0, 1'b0);
        push(l2 + 231, "ign_hold",   18, 3, 1'b1, 1'b0, 1'b0);
        push(l2 + 232, "ign_phase",  18, 2, 1'b1, 1'b0, 1'b0);
        push(s,        "short_acc",  14, 0, 1'b1, 1'b0, 1'b0);
        push(s + 3,    "short_hold", 14, 0, 1'b1, 1'b0, 1'b0);
        push(s + 4,    "short_dec",  13, 9, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        load_full = 1'b0;
        wait_until(l2 + 228);
        load_short = 1'b1;
        @(negedge clock);
        load_short = 1'b0;
        wait_until(l2 + 573);
        load_short = 1'b1;
        @(negedge clock);
        load_short = 1'b0;

        // Pause keeps the partial tenth
        push(s + 11, "pause_in",   13, 8, 1'b0, 1'b0, 1'b0);
        push(s + 35, "pause_mid",  13, 8, 1'b0, 1'b0, 1'b0);
        push(s + 60, "pause_end",  13, 8, 1'b0, 1'b0, 1'b0);
        push(s + 61, "resume",     13, 8, 1'b1, 1'b0, 1'b0);
        push(s + 62, "resume_dec", 13, 7, 1'b1, 1'b0, 1'b0);
        push(s + 66, "after_dec",  13, 6, 1'b1, 1'b0, 1'b0);
        wait_until(s + 10);
        pause = 1'b1;
        wait_until(s + 60);
        pause = 1'b0;

        // Both loads together at 5.0, then load_full held for three edges
        f = s + 412;
        push(f,     "both_loads", 24, 0, 1'b1, 1'b0, 1'b0);
        push(f + 1, "held_load",  24, 0, 1'b1, 1'b0, 1'b0);
        push(f + 5, "held_phase", 24, 0, 1'b1, 1'b0, 1'b0);
        push(f + 6, "held_dec",   23, 9, 1'b1, 1'b0, 1'b0);
        wait_until(s + 411);
        load_full = 1'b1; load_short = 1'b1;
        wait_until(f);
        load_short = 1'b0;
        wait_until(f + 2);
        load_full = 1'b0;

        // load_short in the middle of the buzzer pulse
        e = f + 964;
        push(f + 961, "pre_exp2",   0, 1, 1'b1, 1'b0, 1'b0);
        push(f + 962, "expiry2",    0, 0, 1'b0, 1'b1, 1'b1);
        push(f + 963, "buz2",       0, 0, 1'b0, 1'b1, 1'b1);
        push(e,       "buzz_abort", 14, 0, 1'b1, 1'b0, 1'b0);
        push(e + 1,   "abort_hold", 14, 0, 1'b1, 1'b0, 1'b0);
        push(e + 4,   "abort_dec",  13, 9, 1'b1, 1'b0, 1'b0);
        wait_until(f + 963);
        load_short = 1'b1;
        @(negedge clock);
        load_short = 1'b0;

        // Asynchronous reset at 7.4 while running
        push(e + 265, "pre_rst", 7, 4, 1'b1, 1'b0, 1'b0);
        wait_until(e + 265);
        #2;
        reset_n = 1'b0; pause = 1'b1;
        #1;
        push(pcyc, "async_rst", 24, 0, 1'b0, 1'b0, 1'b0);
        ->chk_now;
        wait_until(e + 268);
        reset_n = 1'b1;
        q0 = pcyc;
        push(q0 + 1,  "rst_paused1", 24, 0, 1'b0, 1'b0, 1'b0);
        push(q0 + 10, "rst_paused2", 24, 0, 1'b0, 1'b0, 1'b0);
        push(q0 + 20, "rst_paused3", 24, 0, 1'b0, 1'b0, 1'b0);
        wait_until(q0 + 20);
        pause = 1'b0;
        q = pcyc;
        push(q + 1, "rst_run",     24, 0, 1'b1, 1'b0, 1'b0);
        push(q + 3, "fresh_phase", 24, 0, 1'b1, 1'b0, 1'b0);
        push(q + 4, "fresh_dec",   23, 9, 1'b1, 1'b0, 1'b0);
        wait_until(q + 6);

        if (sb.size() != 0) begin
            total += sb.size();
            bad   += sb.size();
            $display("FAIL leftover got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
